exibidor_sequencia: RTL

- Playback controller for the sequence-memory game: shows the stored sequence on the LEDs before the player is asked to repeat it.
- Reads the sequence memory from address 0 up to a limit address (inclusive), one entry at a time. Each entry is lit for T_ON cycles, then blanked for T_OFF cycles.
- Sits between the game control unit (which pulses iniciar and waits for pronto) and the sequence ROM/LED outputs. It is the output-side counterpart of the player-input/compare path.

---
 rtl/exibidor_sequencia.sv | 104 ++++++++++
 1 files changed

// File: rtl/exibidor_sequencia.sv
// exibidor_sequencia: plays the stored game sequence on the LEDs.
// It walks the sequence memory from address 0 up to limite, inclusive.
// Each entry is lit for T_ON cycles and then blanked for T_OFF cycles.
// When the last entry has been shown it pulses pronto for one cycle.
//
// state   | code | meaning
// ocioso  | 0    | idle, waiting for iniciar
// prepara | 1    | clear address and timer
// acende  | 2    | current entry lit for T_ON cycles
// apaga   | 3    | blank gap of T_OFF cycles, then check limite
// proximo | 4    | advance to the next address
// fim     | 5    | one-cycle pronto, then back to idle
module exibidor_sequencia #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int T_ON   = 1000,
    parameter int T_OFF  = 500
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] limite,
    input  logic [DATA_W-1:0] dado_rom,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              exibindo,
    output logic              pronto,
    output logic [2:0]        db_estado
);

    localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [TW-1:0] ON_LAST  = TW'(T_ON - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(T_OFF - 1);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        PREPARA = 3'd1,
        ACENDE  = 3'd2,
        APAGA   = 3'd3,
        PROXIMO = 3'd4,
        FIM     = 3'd5
    } estado_t;

    estado_t         estado;
    logic [TW-1:0]   timer;

    // State, address and phase timer. The limite check in apaga happens
    // before any increment, so endereco never wraps past the last entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado   <= OCIOSO;
            endereco <= '0;
            timer    <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (iniciar) estado <= PREPARA;
                end
                PREPARA: begin
                    endereco <= '0;
                    timer    <= '0;
                    estado   <= ACENDE;
                end
                ACENDE: begin
                    if (timer == ON_LAST) begin
                        timer  <= '0;
                        estado <= APAGA;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                APAGA: begin
                    if (timer == OFF_LAST) begin
                        timer  <= '0;
                        estado <= (endereco == limite) ? FIM : PROXIMO;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                PROXIMO: begin
                    endereco <= endereco + ADDR_W'(1);
                    estado   <= ACENDE;
                end
                FIM: begin
                    estado <= OCIOSO;
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

    // Outputs are pure decodes of the state register; leds also passes
    // the memory data through while an entry is lit.
    always_comb begin
        leds      = (estado == ACENDE) ? dado_rom : '0;
        exibindo  = (estado != OCIOSO);
        pronto    = (estado == FIM);
        db_estado = estado;
    end

endmodule
